// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: turns pipeline loads/stores into word-wide,
// byte-enabled bus transactions and returns extended load data with a done pulse.
module dmem_ctrl #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_access_done,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                f3_ok, misal, illegal, expired;
    logic [3:0]          be_n;
    logic [31:0]         wdata_n;
    logic                unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'h0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
        endcase
        misal   = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);
        illegal = (mem_rd && mem_wr) || !f3_ok || misal;

        // Stores replicate the datum across every lane it could occupy.
        be_n    = 4'b1111;
        wdata_n = wdata;
        if (mem_wr) begin
            case (funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << addr[1:0];
                    wdata_n = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << addr[1:0];
                    wdata_n = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        expired = (cnt_q == CNT_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if ((mem_rd || mem_wr) && sdram_init_done) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!illegal) begin
                        state_d = REQ;
                        err_d   = 1'b0;
                        addr_d  = addr[ADDR_W+1:2];
                        we_d    = mem_wr;
                        be_d    = be_n;
                        wdata_d = wdata_n;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_ack && we_q) begin
                    state_d = DONE;
                end else if (bus_ack && bus_rvalid) begin
                    rdata_d = extract(bus_rdata, off_q, f3_q);
                    state_d = DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else if (bus_ack) begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid) begin
                    rdata_d = extract(bus_rdata, off_q, f3_q);
                    state_d = DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_req         = (state_q == REQ);
    assign mem_access_done = (state_q == DONE);
    assign mem_err         = (state_q == DONE) && err_q;
    assign bus_we          = we_q;
    assign bus_addr        = addr_q;
    assign bus_be          = be_q;
    assign bus_wdata       = wdata_q;
    assign rdata           = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random loads/stores
// against a transaction-level model with a cycle-scripted bus responder.
module tb_dmem_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n, sdram_init_done, mem_rd, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        mem_access_done, mem_err, bus_req, bus_we;
    logic [22:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack, bus_rvalid;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata = '0;

    dmem_ctrl #(.ADDR_W(23), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .mem_access_done(mem_access_done), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                                      input logic [31:0] a);
        int size;
        if (rd && wr) return 1'b1;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [31:0] a,
                                               input logic [2:0] f3);
        int size;
        logic [31:0] mask, v;
        size = 1 << f3[1:0];
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
        v = (w >> (8 * (a % 4))) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    // Cycle 0 is the IDLE cycle in which the request is presented.
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int da, input int dr, input logic [31:0] rdat);
        bit ill, exp_err, timed_out, done_seen;
        int size, last, exp_cyc, exp_reqs, reqs, cyc, k;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        ill  = is_illegal(rd, wr, f3, a);
        size = 1 << f3[1:0];
        ebe  = 4'hF;
        ewd  = wd;
        if (wr && size < 4) begin
            ebe = 4'((((1 << size) - 1) << (a % 4)));
            ewd = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 : (wd & 32'hFFFF) * 32'h0001_0001;
        end
        last      = wr ? da : da + dr;
        timed_out = !ill && last > T - 1;
        exp_err   = ill || timed_out;
        exp_cyc   = ill ? 1 : (timed_out ? T + 1 : last + 2);
        exp_reqs  = ill ? 0 : ((da + 1 < T) ? da + 1 : T);

        sdram_init_done = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        bus_rdata = rdat;
        cyc = 0; reqs = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            k = cyc - 1;
            bus_ack = 1'b0; bus_rvalid = 1'b0;
            if (bus_req) begin
                reqs++;
                chk("bus_addr", 32'(bus_addr), a[24:2]);
                chk("bus_we", 32'(bus_we), 32'(wr));
                chk("bus_be", 32'(bus_be), 32'(ebe));
                if (wr) chk("bus_wdata", bus_wdata, ewd);
            end
            if (mem_access_done) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, exp_cyc);
                chk("err", 32'(mem_err), 32'(exp_err));
                chk("req_cycles", reqs, exp_reqs);
                if (timed_out) exp_rdata = '0;
                else if (!ill && rd) exp_rdata = load_value(rdat, a, f3);
                chk("rdata", rdata, exp_rdata);
            end else begin
                chk("err_outside_done", 32'(mem_err), 0);
                if (!ill) begin
                    bus_ack    = bus_req && (k == da);
                    bus_rvalid = rd && (k == da + dr);
                end
            end
        end
        if (!done_seen) chk("done_wait_expired", 0, 1);
        mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(mem_access_done), 0);
        chk("idle_no_req", 32'(bus_req), 0);
    endtask

    initial begin
        logic [2:0] f3_tab [13];
        int r, da, dr;
        bit rd, wr;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        rst_n = 1'b0; sdram_init_done = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        funct3 = '0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_done", 32'(mem_access_done), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 0, 0);
        txn(1, 0, 3'b000, 32'h103, 0, 0, 3, 32'h8012_3456);
        chk("lb_value", rdata, 32'hFFFF_FF80);
        txn(1, 0, 3'b100, 32'h103, 0, 0, 3, 32'h8012_3456);
        chk("lbu_value", rdata, 32'h0000_0080);
        txn(1, 0, 3'b101, 32'h102, 0, 0, 3, 32'h8012_3456);
        chk("lhu_value", rdata, 32'h0000_8012);
        txn(0, 1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 0);
        txn(0, 1, 3'b000, 32'h101, 32'h0000_00AB, 1, 0, 0);
        txn(1, 0, 3'b010, 32'h101, 0, 0, 0, 32'h1111_1111);
        txn(1, 0, 3'b011, 32'h100, 0, 0, 0, 32'h2222_2222);
        txn(1, 1, 3'b010, 32'h100, 0, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h204, 0, 0, 0, 32'hCAFE_F00D);
        txn(1, 0, 3'b010, 32'h208, 0, 7, 0, 32'h1234_5678);
        txn(1, 0, 3'b010, 32'h20C, 0, 7, 1, 32'h9999_9999);
        txn(0, 1, 3'b010, 32'h210, 32'h5555_5555, 50, 0, 0);
        txn(1, 0, 3'b001, 32'h212, 0, 50, 0, 32'h7777_7777);
        chk("timeout_rdata_zero", rdata, 0);

        // Backend not ready: request must wait.
        sdram_init_done = 1'b0; mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("init_low_no_req", 32'(bus_req), 0);
            chk("init_low_no_done", 32'(mem_access_done), 0);
        end
        txn(1, 0, 3'b010, 32'h300, 0, 0, 0, 32'hA5A5_5A5A);

        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r > 5);
            da = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
            dr = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
            txn(rd, wr, f3_tab[$urandom_range(0, 12)], $urandom, $urandom, da, dr, $urandom);
        end

        // Reset while waiting for read data.
        sdram_init_done = 1'b1; mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        chk("rw_in_req", 32'(bus_req), 1);
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0; mem_rd = 1'b0;
        chk("rw_in_rwait", 32'(bus_req), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus_req), 0);
        chk("rst_mid_done", 32'(mem_access_done), 0);
        chk("rst_mid_err", 32'(mem_err), 0);
        chk("rst_mid_rdata", rdata, 0);
        exp_rdata = '0;
        #2 rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stale_rvalid_done", 32'(mem_access_done), 0);
            chk("stale_rvalid_rdata", rdata, 0);
        end
        bus_rvalid = 1'b0;
        txn(1, 0, 3'b000, 32'h401, 0, 1, 1, 32'h0000_7F00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory responder for the MEM stage. It accepts load/store requests from the pipeline and translates them into word-wide, byte-enabled transactions on the SDRAM-side bus. It returns aligned, extended load data and a one-cycle mem_access_done pulse. The hazard controller holds EX/MEM and MEM/WB stalled on load/store until this pulse arrives.

Parameters:
ADDR_W, 23, width of the bus word address (byte address bits [ADDR_W+1:2])
TIMEOUT, 255, max cycles spent in REQ+RWAIT before the access is aborted with an error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sdram_init_done  in  1  backend ready; no request is accepted while low
mem_rd  in  1  MEM-stage instruction is LOAD
mem_wr  in  1  MEM-stage instruction is STORE
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
wdata  in  32  store data (low-aligned)
rdata  out  32  extended load result
mem_access_done  out  1  one-cycle completion pulse
mem_err  out  1  valid with done: misaligned, illegal funct3, rd&wr both high, or timeout
bus_req  out  1  transaction request
bus_we  out  1  1=write
bus_addr  out  ADDR_W  word address
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated write data
bus_ack  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction aborts it; bus_req drops immediately.
- FSM states: IDLE, REQ, RWAIT, DONE.
- IDLE:
  - Waits for (mem_rd|mem_wr) && sdram_init_done.
  - Illegal request goes to DONE with err=1 and no bus activity. Illegal means: rd&wr both high, funct3 not in {000,001,010,100,101}, H with addr[0]=1, or W with addr[1:0]!=0.
  - Otherwise latch addr, we, be, wdata, funct3, offset; clear counter; go to REQ.
- REQ:
  - bus_req=1; addr/we/be/wdata held stable until bus_ack.
  - On ack, a write goes to DONE.
  - On ack, a read goes to RWAIT; if bus_rvalid is in the same cycle, capture and go to DONE.
- RWAIT: on bus_rvalid, capture the extracted data into rdata and go to DONE.
- DONE: mem_access_done=1 for exactly one cycle, mem_err valid alongside it; next state IDLE.
- mem_err is 0 outside DONE.
- Timeout:
  - The counter increments every cycle in REQ/RWAIT.
  - If it reaches TIMEOUT-1 with no completing event that cycle, go to DONE with err=1, rdata=0, bus_req=0.
- Latency:
  - Request seen in IDLE at cycle 0; bus_req at cycle 1.
  - With immediate ack (plus rvalid for a read), done is at cycle 2.
  - Illegal request: done+err at cycle 1.
- Write lanes:
  - SB: bus_wdata={4{wdata[7:0]}}, be=0001<<addr[1:0].
  - SH: bus_wdata={2{wdata[15:0]}}, be=0011<<addr[1:0].
  - SW: bus_wdata=wdata, be=1111.
- Reads: bus_be=1111.
- Load extract:
  - B/BU select byte lane addr[1:0]; H/HU select half addr[1]; W takes the full word.
  - B/H sign-extend; BU/HU zero-extend.
- rdata holds its value until the next read completes; writes and errors other than timeout leave it unchanged.
- bus_rvalid outside RWAIT/REQ-with-ack is ignored. bus_ack outside REQ is ignored.
- After DONE the pipeline advances. A back-to-back request is seen in IDLE the following cycle, with no dead cycle beyond IDLE.

Test Plan:
1. SW addr=0x100 wdata=0xDEADBEEF, bus_ack 2 cycles after bus_req -> bus_addr=0x40, be=1111, we=1, done=1 for one cycle the cycle after ack, err=0.
2. LB addr=0x103, bus_rdata=0x80123456 with rvalid 3 cycles after ack -> rdata=0xFFFFFF80; repeat as LBU -> rdata=0x00000080; LHU addr=0x102 -> 0x00008012.
3. SH addr=0x102 wdata=0x00001234 -> bus_wdata=0x12341234, be=1100; SB addr=0x101 wdata=0xAB -> be=0010, bus_wdata=0xABABABAB.
4. LW addr=0x101 -> no bus_req ever, done=1 and err=1 at cycle 1; funct3=011 behaves identically.
5. TIMEOUT=8, bus_ack never asserted -> bus_req high exactly 8 cycles, then done=1 with err=1, rdata=0, FSM returns to IDLE.
6. mem_rd=1 with sdram_init_done=0 for 5 cycles -> no bus_req; raise init_done -> bus_req next cycle. Separately, assert rst_n=0 while in RWAIT -> bus_req/done/err=0 immediately; a stale rvalid after release is ignored.
